// File: rtl/typewriter_pkg.sv
// Shared ASCII constants, printable-range test and output-FSM state type
// for the typewriter print path.
package typewriter_pkg;

    localparam logic [7:0] ASCII_LF  = 8'h0A;
    localparam logic [7:0] ASCII_CR  = 8'h0D;
    localparam logic [7:0] ASCII_NUL = 8'h00;
    localparam logic [7:0] PRN_WAKE  = 8'hFF;
    localparam logic [7:0] PRINT_LO  = 8'h20;
    localparam logic [7:0] PRINT_HI  = 8'h7E;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP
    } out_state_e;

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= PRINT_LO) && (c <= PRINT_HI);
    endfunction

endpackage

// File: rtl/print_queue_if.sv
// Upstream valid/ready byte channel plus the print_control rdy/ascii/done
// handshake, bundled for the print queue.
interface print_queue_if #(
    parameter int DEPTH = 16
);
    logic                   in_valid;
    logic [7:0]             in_char;
    logic                   in_ready;
    logic                   rdy;
    logic [7:0]             ascii;
    logic                   done;
    logic [$clog2(DEPTH):0] level;

    modport master (output in_valid, in_char, done,
                    input  in_ready, rdy, ascii, level);
    modport slave  (input  in_valid, in_char, done,
                    output in_ready, rdy, ascii, level);
endinterface

// File: rtl/char_fifo.sv
// Synchronous FIFO with power-of-two depth; head is read straight from the
// register array so it is valid the cycle after the first write.
module char_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             do_push, do_pop;

    assign full  = (level_q == (AW+1)'(DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        level_d  = level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage carries no reset: empty/level gate every read.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/print_queue.sv
// Byte queue feeding print_control: filters NUL/wake bytes, inserts LF at
// line end, and enforces a head-settle gap between offered characters.
module print_queue
    import typewriter_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int LINE_LEN   = 32,
    parameter int GAP_CYCLES = 50000
) (
    input  logic          clk,
    input  logic          rst,
    print_queue_if.slave  pq
);
    localparam int CW = $clog2(LINE_LEN + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [CW-1:0] COL_MAX  = CW'(LINE_LEN);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    out_state_e            state_q, state_d;
    logic                  rdy_q, rdy_d;
    logic [7:0]            ascii_q, ascii_d;
    logic                  ins_lf_q, ins_lf_d;
    logic [CW-1:0]         col_q, col_d;
    logic [GW-1:0]         gap_q, gap_d;

    logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]            fifo_head;
    logic [$clog2(DEPTH):0] fifo_level;

    assign pq.in_ready = ~fifo_full;
    assign pq.rdy      = rdy_q;
    assign pq.ascii    = ascii_q;
    assign pq.level    = fifo_level;

    // Filtered bytes still complete the handshake but never enter storage.
    assign fifo_push = pq.in_valid && !fifo_full &&
                       (pq.in_char != ASCII_NUL) && (pq.in_char != PRN_WAKE);

    char_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (pq.in_char),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_comb begin
        state_d  = state_q;
        rdy_d    = rdy_q;
        ascii_d  = ascii_q;
        ins_lf_d = ins_lf_q;
        col_d    = col_q;
        gap_d    = gap_q;
        fifo_pop = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    state_d = S_SEND;
                    rdy_d   = 1'b1;
                    // A full line defers the head char behind a generated LF.
                    if (is_printable(fifo_head) && (col_q == COL_MAX)) begin
                        ins_lf_d = 1'b1;
                        ascii_d  = ASCII_LF;
                    end else begin
                        fifo_pop = 1'b1;
                        ascii_d  = fifo_head;
                    end
                end
            end
            S_SEND: begin
                if (pq.done) begin
                    state_d = S_GAP;
                    rdy_d   = 1'b0;
                    ascii_d = ASCII_NUL;
                    gap_d   = '0;
                    if ((ascii_q == ASCII_LF) || (ascii_q == ASCII_CR)) begin
                        col_d    = '0;
                        ins_lf_d = 1'b0;
                    end else if (is_printable(ascii_q)) begin
                        col_d = col_q + CW'(1);
                    end
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) state_d = S_IDLE;
                else                   gap_d   = gap_q + GW'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            rdy_q    <= 1'b0;
            ascii_q  <= ASCII_NUL;
            ins_lf_q <= 1'b0;
            col_q    <= '0;
            gap_q    <= '0;
        end else begin
            state_q  <= state_d;
            rdy_q    <= rdy_d;
            ascii_q  <= ascii_d;
            ins_lf_q <= ins_lf_d;
            col_q    <= col_d;
            gap_q    <= gap_d;
        end
    end

endmodule

// File: tb/tb_print_queue.sv
// Bench for print_queue: directed scenarios plus a randomized run checked
// against a character-stream model of the queue and line counter.
module tb_print_queue;
    localparam int DEPTH      = 8;
    localparam int LINE_LEN   = 4;
    localparam int GAP_CYCLES = 3;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    print_queue_if #(.DEPTH(DEPTH)) pq ();

    print_queue #(
        .DEPTH(DEPTH), .LINE_LEN(LINE_LEN), .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .pq  (pq.slave)
    );

    always #5 clk = ~clk;

    function automatic bit printable(input logic [7:0] c);
        return (c >= 8'd32) && (c <= 8'd126);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] c);
        pq.in_valid = 1'b1;
        pq.in_char  = c;
        tick();
        pq.in_valid = 1'b0;
        pq.in_char  = 8'h00;
    endtask

    task automatic pulse_done();
        pq.done = 1'b1;
        tick();
        pq.done = 1'b0;
    endtask

    task automatic wait_offer(output logic [7:0] ch, output bit ok);
        ok = 1'b0;
        ch = 8'h00;
        for (int i = 0; i < 100; i++) begin
            if (pq.rdy === 1'b1) begin
                ch = pq.ascii;
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic apply_reset();
        pq.in_valid = 1'b0;
        pq.in_char  = 8'h00;
        pq.done     = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        pq.done     = 1'b0;
        pq.in_valid = 1'b1;
        pq.in_char  = 8'h41;
        rst = 1'b1;
        tick(); tick(); tick();
        n_tests++;
        if (pq.rdy !== 1'b0 || pq.ascii !== 8'h00 || pq.level !== 4'd0 || pq.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_values: rdy=%b ascii=%h level=%0d in_ready=%b, want 0/00/0/1",
                     pq.rdy, pq.ascii, pq.level, pq.in_ready);
        end
        pq.in_valid = 1'b0;
        rst = 1'b0;
        tick(); tick(); tick(); tick();
        n_tests++;
        if (pq.rdy !== 1'b0 || pq.level !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_push_ignored: rdy=%b level=%0d, want 0/0", pq.rdy, pq.level);
        end
    endtask

    task automatic test_single();
        apply_reset();
        push_byte(8'h41);
        n_tests++;
        if (pq.rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_early: rdy=%b one cycle after push, want 0", pq.rdy);
        end
        tick();
        n_tests++;
        if (pq.rdy !== 1'b1 || pq.ascii !== 8'h41 || pq.level !== 4'd0) begin
            n_fail++;
            $display("FAIL single_offer: rdy=%b ascii=%h level=%0d, want 1/41/0", pq.rdy, pq.ascii, pq.level);
        end
        pulse_done();
        for (int i = 0; i < GAP_CYCLES + 1; i++) begin
            n_tests++;
            if (pq.rdy !== 1'b0 || pq.ascii !== 8'h00) begin
                n_fail++;
                $display("FAIL single_gap[%0d]: rdy=%b ascii=%h, want 0/00", i, pq.rdy, pq.ascii);
            end
            tick();
        end
    endtask

    task automatic test_repeat();
        logic [7:0] ch;
        bit ok;
        int cnt;
        apply_reset();
        push_byte(8'h41);
        push_byte(8'h41);
        wait_offer(ch, ok);
        n_tests++;
        if (!ok || ch !== 8'h41) begin
            n_fail++;
            $display("FAIL repeat_first: ok=%b ascii=%h, want 1/41", ok, ch);
        end
        pulse_done();
        n_tests++;
        if (pq.rdy !== 1'b0 || pq.ascii !== 8'h00) begin
            n_fail++;
            $display("FAIL repeat_between: rdy=%b ascii=%h, want 0/00", pq.rdy, pq.ascii);
        end
        cnt = 1;
        while (pq.rdy !== 1'b1 && cnt < 100) begin
            tick();
            cnt++;
        end
        n_tests++;
        if (cnt != GAP_CYCLES + 2 || pq.ascii !== 8'h41) begin
            n_fail++;
            $display("FAIL repeat_second: offer after %0d cycles ascii=%h, want %0d/41",
                     cnt, pq.ascii, GAP_CYCLES + 2);
        end
    endtask

    task automatic test_fill();
        int pushes;
        int cnt;
        apply_reset();
        pushes = 0;
        pq.in_valid = 1'b1;
        while (pq.in_ready === 1'b1 && pushes < 40) begin
            pq.in_char = 8'h61 + 8'(pushes);
            tick();
            pushes++;
        end
        pq.in_char = 8'h7A;
        n_tests++;
        if (pushes != DEPTH + 1 || pq.level !== 4'(DEPTH) || pq.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_full: pushes=%0d level=%0d in_ready=%b, want %0d/%0d/0",
                     pushes, pq.level, pq.in_ready, DEPTH + 1, DEPTH);
        end
        tick();
        pq.in_valid = 1'b0;
        n_tests++;
        if (pq.level !== 4'(DEPTH) || pq.rdy !== 1'b1 || pq.ascii !== 8'h61) begin
            n_fail++;
            $display("FAIL fill_overflow: level=%0d rdy=%b ascii=%h, want %0d/1/61",
                     pq.level, pq.rdy, pq.ascii, DEPTH);
        end
        pulse_done();
        cnt = 1;
        while (pq.in_ready !== 1'b1 && cnt < 100) begin
            tick();
            cnt++;
        end
        n_tests++;
        if (cnt != GAP_CYCLES + 2 || pq.level !== 4'(DEPTH - 1) || pq.ascii !== 8'h62) begin
            n_fail++;
            $display("FAIL fill_drain: in_ready after %0d cycles level=%0d ascii=%h, want %0d/%0d/62",
                     cnt, pq.level, pq.ascii, GAP_CYCLES + 2, DEPTH - 1);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_a [6] = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h0A, 8'h45};
        logic [7:0] exp_b [6] = '{8'h46, 8'h47, 8'h48, 8'h49, 8'h0A, 8'h4A};
        logic [7:0] ch;
        bit ok;
        apply_reset();
        for (int i = 0; i < 5; i++) push_byte(8'h41 + 8'(i));
        for (int i = 0; i < 6; i++) begin
            wait_offer(ch, ok);
            n_tests++;
            if (!ok || ch !== exp_a[i]) begin
                n_fail++;
                $display("FAIL wrap_a[%0d]: ok=%b ascii=%h, want %h", i, ok, ch, exp_a[i]);
            end
            pulse_done();
        end
        push_byte(8'h0D);
        wait_offer(ch, ok);
        n_tests++;
        if (!ok || ch !== 8'h0D) begin
            n_fail++;
            $display("FAIL wrap_cr: ok=%b ascii=%h, want 0d", ok, ch);
        end
        pulse_done();
        for (int i = 0; i < 5; i++) push_byte(8'h46 + 8'(i));
        for (int i = 0; i < 6; i++) begin
            wait_offer(ch, ok);
            n_tests++;
            if (!ok || ch !== exp_b[i]) begin
                n_fail++;
                $display("FAIL wrap_b[%0d]: ok=%b ascii=%h, want %h", i, ok, ch, exp_b[i]);
            end
            pulse_done();
        end
    endtask

    task automatic test_filter();
        logic [7:0] ch;
        logic [7:0] seq [3] = '{8'h00, 8'hFF, 8'h42};
        bit ok;
        int peak;
        bit stray;
        apply_reset();
        peak = 0;
        for (int i = 0; i < 3; i++) begin
            push_byte(seq[i]);
            if (int'(pq.level) > peak) peak = int'(pq.level);
        end
        tick();
        if (int'(pq.level) > peak) peak = int'(pq.level);
        n_tests++;
        if (peak != 1) begin
            n_fail++;
            $display("FAIL filter_peak: level peak %0d, want 1", peak);
        end
        wait_offer(ch, ok);
        n_tests++;
        if (!ok || ch !== 8'h42) begin
            n_fail++;
            $display("FAIL filter_offer: ok=%b ascii=%h, want 1/42", ok, ch);
        end
        pulse_done();
        stray = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (pq.rdy !== 1'b0) stray = 1'b1;
            tick();
        end
        n_tests++;
        if (stray || pq.level !== 4'd0) begin
            n_fail++;
            $display("FAIL filter_extra: stray offer=%b level=%0d, want 0/0", stray, pq.level);
        end
    endtask

    task automatic test_reset_flight();
        bit stray;
        apply_reset();
        for (int i = 0; i < 4; i++) push_byte(8'h70 + 8'(i));
        n_tests++;
        if (pq.rdy !== 1'b1 || pq.level !== 4'd3) begin
            n_fail++;
            $display("FAIL flight_setup: rdy=%b level=%0d, want 1/3", pq.rdy, pq.level);
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if (pq.rdy !== 1'b0 || pq.level !== 4'd0 || pq.ascii !== 8'h00) begin
            n_fail++;
            $display("FAIL flight_async: rdy=%b level=%0d ascii=%h, want 0/0/00", pq.rdy, pq.level, pq.ascii);
        end
        tick();
        rst = 1'b0;
        stray = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (pq.rdy !== 1'b0) stray = 1'b1;
            tick();
        end
        n_tests++;
        if (stray) begin
            n_fail++;
            $display("FAIL flight_after: offer seen after reset release, want none");
        end
    endtask

    task automatic test_random();
        logic [7:0] mq [$];
        int mcol;
        bit offered;
        logic [7:0] cur_exp;
        int since_done;
        apply_reset();
        mcol = 0;
        offered = 1'b0;
        cur_exp = 8'h00;
        since_done = 1000;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            logic [7:0] c;
            logic [7:0] exp_ch;
            bit do_done, do_push, acc;
            int r;
            if (pq.rdy === 1'b1 && !offered) begin
                offered = 1'b1;
                exp_ch = 8'hEE;
                if (mq.size() != 0) begin
                    if (printable(mq[0]) && mcol == LINE_LEN) exp_ch = 8'h0A;
                    else exp_ch = mq.pop_front();
                end
                cur_exp = exp_ch;
                n_tests++;
                if (pq.ascii !== exp_ch) begin
                    n_fail++;
                    $display("FAIL rand_offer@%0d: ascii=%h, want %h", cyc, pq.ascii, exp_ch);
                end
                n_tests++;
                if (since_done < GAP_CYCLES + 2) begin
                    n_fail++;
                    $display("FAIL rand_spacing@%0d: offer %0d cycles after done, want >= %0d",
                             cyc, since_done, GAP_CYCLES + 2);
                end
            end
            if (pq.rdy !== 1'b1) begin
                n_tests++;
                if (pq.ascii !== 8'h00) begin
                    n_fail++;
                    $display("FAIL rand_idle_ascii@%0d: ascii=%h, want 00", cyc, pq.ascii);
                end
            end
            n_tests++;
            if (int'(pq.level) !== mq.size()) begin
                n_fail++;
                $display("FAIL rand_level@%0d: level=%0d, want %0d", cyc, pq.level, mq.size());
            end
            r = $urandom_range(0, 9);
            if (r < 5)       c = 8'($urandom_range(32, 126));
            else if (r == 5) c = 8'h00;
            else if (r == 6) c = 8'hFF;
            else if (r == 7) c = 8'h0A;
            else if (r == 8) c = 8'h0D;
            else             c = 8'h01 + 8'($urandom_range(0, 7));
            do_push = (cyc < 1300) && ($urandom_range(0, 3) == 0);
            do_done = offered ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
            acc = do_push && (pq.in_ready === 1'b1);
            pq.done     = do_done;
            pq.in_valid = do_push;
            pq.in_char  = c;
            tick();
            pq.done     = 1'b0;
            pq.in_valid = 1'b0;
            if (acc && c != 8'h00 && c != 8'hFF) mq.push_back(c);
            if (do_done && offered) begin
                offered = 1'b0;
                since_done = 1;
                if (cur_exp == 8'h0A || cur_exp == 8'h0D) mcol = 0;
                else if (printable(cur_exp)) mcol++;
            end else begin
                since_done++;
            end
        end
        n_tests++;
        if (mq.size() != 0 || pq.level !== 4'd0 || offered) begin
            n_fail++;
            $display("FAIL rand_drain: model left %0d level=%0d pending=%b, want 0/0/0",
                     mq.size(), pq.level, offered);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_repeat();
        test_fill();
        test_wrap();
        test_filter();
        test_reset_flight();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
